// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage.
// Owns the program counter, drives the word address to a combinational-read
// instruction memory, and captures the returned word into the IF/ID register.
// Handles stall, flush and branch/jump redirect, and stops on an out-of-range PC.
// Optional feature macro: BRANCH_DELAY_SLOT_EN
//   defined   - a redirect in RUN still captures the instruction at the current
//               PC as the delay slot (when that PC is in range).
//   undefined - a redirect squashes the sequential instruction.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | fetching; PC advances by one word per unstalled cycle
// FAULT | PC left the memory; fetch halted until an in-range redirect
module instruction_fetch #(
  parameter int unsigned MEM_SIZE = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] instruction_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [31:0] ipc_d;
  logic [31:0] count_d;
  logic        valid_d;
  logic        capture;
  logic        pc_in_range;
  logic        target_in_range;

  assign pc_in_range     = (PC < MEM_LIMIT);
  assign target_in_range = (redirect_pc < MEM_LIMIT);

  // fault flag is a pure decode of the registered state, so it has no input path
  assign fetch_fault = (state_q == FAULT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, IF/ID register and capture counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC          <= RESET_PC;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
      if_valid    <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      PC          <= pc_d;
      if_instr    <= instr_d;
      if_pc       <= ipc_d;
      if_valid    <= valid_d;
      fetch_count <= count_d;
    end
  end

  // Next-state and datapath decisions; priority redirect > flush > stall > normal
  always_comb begin
    state_d = state_q;
    pc_d    = PC;
    instr_d = if_instr;
    ipc_d   = if_pc;
    valid_d = if_valid;
    count_d = fetch_count;
    capture = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
`ifdef BRANCH_DELAY_SLOT_EN
          // an out-of-range delay slot is dropped silently; the fault is
          // judged later against the redirected PC
          if (pc_in_range) begin
            capture = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
`else
          valid_d = 1'b0;
`endif
        end else if (flush) begin
          // PC holds so the squashed address is refetched next cycle
          valid_d = 1'b0;
        end else if (!stall) begin
          if (pc_in_range) begin
            capture = 1'b1;
            pc_d    = PC + 32'd1;
          end else begin
            state_d = FAULT;
            valid_d = 1'b0;
          end
        end
      end

      FAULT: begin
        valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (target_in_range) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (capture) begin
      instr_d = instruction_in;
      ipc_d   = PC;
      valid_d = 1'b1;
      count_d = fetch_count + 32'd1;
    end
  end

endmodule
